// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM-to-PCM CIC decimator.
//   CIC_ORDER : number of integrator/comb stages
//   state_e   : serial comb sequencer states
//   acc_w     : internal CIC width for a given decimation ratio
//   out_shift : right shift that maps the CIC result onto the PCM width
package pdm_pkg;

   localparam int unsigned CIC_ORDER = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_COMB = 2'd1,
      ST_EMIT = 2'd2
   } state_e;

   function automatic int unsigned acc_w(input int unsigned r);
      return 1 + CIC_ORDER * $clog2(r);
   endfunction

   // Negative result means the PCM word is wider than the CIC growth (left shift).
   function automatic int out_shift(input int unsigned r, input int unsigned out_w);
      return int'(CIC_ORDER * $clog2(r)) - int'(out_w) + 1;
   endfunction

endpackage

// File: rtl/cic_integrator.sv
// One CIC integrator stage: wrapping accumulator advanced only on enabled cycles.
//   addr_clk : clock, reset : synchronous active-high clear
//   en_i     : accumulate enable
//   din_i    : addend (previous stage output or input sample)
//   acc_o    : registered accumulator value
module cic_integrator #(
   parameter int unsigned W = 25
) (
   input  logic         addr_clk,
   input  logic         reset,
   input  logic         en_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] acc_o
);

   logic [W-1:0] acc_q;

   // Modulo-2^W accumulation; wrap-around cancels in the combs.
   always_ff @(posedge addr_clk) begin
      if (reset) begin
         acc_q <= '0;
      end else if (en_i) begin
         acc_q <= acc_q + din_i;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/pdm_cic_decimator.sv
// 4th-order CIC decimator turning a 1-bit PDM stream into signed PCM samples.
//   addr_clk  : PDM bit clock, reset : synchronous active-high
//   pdm_in    : PDM bit, pdm_en : sample qualifier
//   pcm_data  : signed PCM sample, pcm_valid/pcm_ready : output handshake
//   overrun   : sticky flag, set when an unaccepted sample is overwritten
module pdm_cic_decimator
   import pdm_pkg::*;
#(
   parameter int unsigned DEC_R = 64,
   parameter int unsigned OUT_W = 16
) (
   input  logic             addr_clk,
   input  logic             reset,
   input  logic             pdm_in,
   input  logic             pdm_en,
   output logic [OUT_W-1:0] pcm_data,
   output logic             pcm_valid,
   input  logic             pcm_ready,
   output logic             overrun
);

   localparam int unsigned LOG2R      = $clog2(DEC_R);
   localparam int unsigned ACC_W      = acc_w(DEC_R);
   localparam int          SHIFT      = out_shift(DEC_R, OUT_W);
   localparam int unsigned SHR        = (SHIFT > 0) ? $unsigned(SHIFT) : 32'd0;
   localparam int unsigned SHL        = (SHIFT < 0) ? $unsigned(-SHIFT) : 32'd0;
   localparam int unsigned SW         = ACC_W + OUT_W + 4;
   localparam logic [2:0]  WARM_DONE  = 3'(CIC_ORDER);
   localparam logic [1:0]  LAST_STAGE = 2'(CIC_ORDER - 1);
   localparam logic signed [SW-1:0] PCM_MAX    = (SW'(1) <<< (OUT_W - 1)) - SW'(1);
   localparam logic signed [SW-1:0] PCM_MIN    = -PCM_MAX - SW'(1);
   localparam logic        [SW-1:0] FULL_SCALE = SW'(1) << (CIC_ORDER * LOG2R);

   // Frame counter; boundary flag registered so capture lands one cycle later.
   logic [LOG2R-1:0] cnt_q;
   logic             frame_q;
   logic             boundary_c;

   assign boundary_c = pdm_en && (cnt_q == LOG2R'(DEC_R - 1));

   always_ff @(posedge addr_clk) begin
      if (reset) begin
         cnt_q   <= '0;
         frame_q <= 1'b0;
      end else begin
         frame_q <= boundary_c;
         if (pdm_en) cnt_q <= cnt_q + LOG2R'(1);
      end
   end

   // Integrators run on the 0/1 bit; the bipolar sum is recovered after the combs
   // so that +full-scale stays representable in ACC_W bits.
   logic [CIC_ORDER:0][ACC_W-1:0] integ;
   assign integ[0] = ACC_W'(pdm_in);

   for (genvar g = 0; g < CIC_ORDER; g++) begin : g_integ
      cic_integrator #(.W(ACC_W)) u_integ (
         .addr_clk (addr_clk),
         .reset    (reset),
         .en_i     (pdm_en),
         .din_i    (integ[g]),
         .acc_o    (integ[g+1])
      );
   end

   // Comb sequencer state register.
   state_e     state_q, state_d;
   logic [1:0] stage_q, stage_d;
   logic       cap_en_c, comb_en_c, emit_c;

   always_ff @(posedge addr_clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         stage_q <= '0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
      end
   end

   // Next state: capture on boundary, one comb stage per cycle, then emit.
   always_comb begin
      state_d   = state_q;
      stage_d   = stage_q;
      cap_en_c  = 1'b0;
      comb_en_c = 1'b0;
      emit_c    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (frame_q) begin
               cap_en_c = 1'b1;
               stage_d  = '0;
               state_d  = ST_COMB;
            end
         end
         ST_COMB: begin
            comb_en_c = 1'b1;
            stage_d   = stage_q + 2'd1;
            if (stage_q == LAST_STAGE) state_d = ST_EMIT;
         end
         ST_EMIT: begin
            emit_c  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Serial comb datapath with one shared subtractor.
   logic [ACC_W-1:0] w_q;
   logic [ACC_W-1:0] dly_q [CIC_ORDER];
   logic [ACC_W-1:0] diff_c;

   assign diff_c = w_q - dly_q[stage_q];

   always_ff @(posedge addr_clk) begin
      if (reset) begin
         w_q <= '0;
         for (int i = 0; i < int'(CIC_ORDER); i++) dly_q[i] <= '0;
      end else if (cap_en_c) begin
         w_q <= integ[CIC_ORDER];
      end else if (comb_en_c) begin
         w_q            <= diff_c;
         dly_q[stage_q] <= w_q;
      end
   end

   // Bipolar conversion (2u - R^N), scaling and saturation.
   logic signed [SW-1:0] bip_c;
   logic signed [SW-1:0] scl_c;
   logic [OUT_W-1:0]     sample_c;

   always_comb begin
      bip_c = $signed((SW'(w_q) << 1) - FULL_SCALE);
      scl_c = (bip_c >>> SHR) <<< SHL;
      if (scl_c > PCM_MAX) begin
         sample_c = PCM_MAX[OUT_W-1:0];
      end else if (scl_c < PCM_MIN) begin
         sample_c = PCM_MIN[OUT_W-1:0];
      end else begin
         sample_c = scl_c[OUT_W-1:0];
      end
   end

   // Warm-up counter and output handshake registers.
   logic [2:0]       warm_q;
   logic [OUT_W-1:0] pcm_data_q;
   logic             pcm_valid_q;
   logic             overrun_q;

   always_ff @(posedge addr_clk) begin
      if (reset) begin
         warm_q      <= '0;
         pcm_data_q  <= '0;
         pcm_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (emit_c && (warm_q != WARM_DONE)) warm_q <= warm_q + 3'd1;
         if (emit_c && (warm_q == WARM_DONE)) begin
            pcm_data_q  <= sample_c;
            pcm_valid_q <= 1'b1;
            if (pcm_valid_q && !pcm_ready) overrun_q <= 1'b1;
         end else if (pcm_valid_q && pcm_ready) begin
            pcm_valid_q <= 1'b0;
         end
      end
   end

   assign pcm_data  = pcm_data_q;
   assign pcm_valid = pcm_valid_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator (DEC_R=64, OUT_W=16).
module tb_pdm_cic_decimator;

   localparam int unsigned DEC_R = 64;
   localparam int unsigned OUT_W = 16;

   logic             addr_clk = 1'b0;
   logic             reset;
   logic             pdm_in;
   logic             pdm_en;
   logic [OUT_W-1:0] pcm_data;
   logic             pcm_valid;
   logic             pcm_ready;
   logic             overrun;

   pdm_cic_decimator #(.DEC_R(DEC_R), .OUT_W(OUT_W)) dut (
      .addr_clk  (addr_clk),
      .reset     (reset),
      .pdm_in    (pdm_in),
      .pdm_en    (pdm_en),
      .pcm_data  (pcm_data),
      .pcm_valid (pcm_valid),
      .pcm_ready (pcm_ready),
      .overrun   (overrun)
   );

   always #5 addr_clk = ~addr_clk;

   int         n_chk  = 0;
   int         n_fail = 0;
   int         cyc    = 0;
   int         nsamp  = 0;
   logic [3:0] pat    = 4'b0000;
   bit         tog    = 1'b0;

   typedef struct {
      string      name;
      logic [3:0] pat;
      bit         tog;
      int         exp_data;
      int         exp_first;
      int         exp_period;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int pcm_s();
      return int'($signed(pcm_data));
   endfunction

   // Drive one edge: pattern bit by enabled-sample index, optional half-rate enable.
   task automatic step();
      pdm_en = tog ? (((cyc + 1) % 2) == 1) : 1'b1;
      pdm_in = pat[3 - (nsamp % 4)];
      if (pdm_en) nsamp++;
      @(posedge addr_clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      pdm_in = 1'b0;
      pdm_en = 1'b0;
      repeat (2) @(posedge addr_clk);
      #1;
      reset = 1'b0;
      cyc   = 0;
      nsamp = 0;
   endtask

   initial begin
      int first, second, d1, d2, nvalid, lowcnt, budget;

      vecs[0] = '{"ones",   4'b1111, 1'b0,  32767, 326,  64};
      vecs[1] = '{"zeros",  4'b0000, 1'b0, -32768, 326,  64};
      vecs[2] = '{"alt",    4'b1010, 1'b0,      0, 326,  64};
      vecs[3] = '{"p1110",  4'b1110, 1'b0,  16384, 326,  64};
      vecs[4] = '{"en_tog", 4'b1111, 1'b1,  32767, 645, 128};

      reset     = 1'b1;
      pdm_in    = 1'b0;
      pdm_en    = 1'b0;
      pcm_ready = 1'b0;

      // Steady patterns with an always-ready consumer.
      for (int v = 0; v < 5; v++) begin
         pcm_ready = 1'b0;
         do_reset();
         chk({vecs[v].name, "_rst_valid"},   int'(pcm_valid), 0);
         chk({vecs[v].name, "_rst_overrun"}, int'(overrun),   0);
         chk({vecs[v].name, "_rst_data"},    pcm_s(),         0);
         pat       = vecs[v].pat;
         tog       = vecs[v].tog;
         pcm_ready = 1'b1;
         first = -1; second = -1; d1 = 0; d2 = 0; nvalid = 0;
         budget = vecs[v].exp_first + vecs[v].exp_period + 10;
         for (int c = 0; c < budget; c++) begin
            step();
            if (pcm_valid) begin
               nvalid++;
               if (first < 0) begin
                  first = cyc; d1 = pcm_s();
               end else if (second < 0) begin
                  second = cyc; d2 = pcm_s();
               end
            end
         end
         chk({vecs[v].name, "_first_cycle"}, first,          vecs[v].exp_first);
         chk({vecs[v].name, "_data1"},       d1,             vecs[v].exp_data);
         chk({vecs[v].name, "_period"},      second - first, vecs[v].exp_period);
         chk({vecs[v].name, "_data2"},       d2,             vecs[v].exp_data);
         chk({vecs[v].name, "_valid_count"}, nvalid,         2);
         chk({vecs[v].name, "_no_overrun"},  int'(overrun),  0);
      end
      tog = 1'b0;

      // Overrun: consumer stalls across several emits, then one ready pulse.
      pcm_ready = 1'b0;
      do_reset();
      pat = 4'b0000;
      repeat (325) step();
      chk("ovr_pre_first_valid", int'(pcm_valid), 0);
      step();
      chk("ovr_first_valid", int'(pcm_valid), 1);
      chk("ovr_first_data",  pcm_s(),         -32768);
      pat = 4'b1111;
      repeat (63) step();
      chk("ovr_held_valid",    int'(pcm_valid), 1);
      chk("ovr_held_data",     pcm_s(),         -32768);
      chk("ovr_before_second", int'(overrun),   0);
      step();
      chk("ovr_set",          int'(overrun),   1);
      chk("ovr_valid_kept",   int'(pcm_valid), 1);
      repeat (646 - 390) step();
      chk("ovr_latest_data",  pcm_s(),         32767);
      chk("ovr_valid_frame10", int'(pcm_valid), 1);
      pcm_ready = 1'b1;
      step();
      pcm_ready = 1'b0;
      chk("ovr_ready_clears_valid", int'(pcm_valid), 0);
      chk("ovr_sticky",             int'(overrun),   1);

      // Emit coinciding with a handshake on the previous sample.
      pcm_ready = 1'b0;
      do_reset();
      pat = 4'b0000;
      repeat (326) step();
      chk("hs_first_data", pcm_s(), -32768);
      pat = 4'b1111;
      lowcnt = 0;
      while (cyc < 646) begin
         pcm_ready = ((cyc + 1) >= 390) && ((((cyc + 1) - 390) % 64) == 0);
         step();
         if (!pcm_valid) lowcnt++;
      end
      pcm_ready = 1'b0;
      chk("hs_valid_never_dropped", lowcnt,           0);
      chk("hs_new_data",            pcm_s(),          32767);
      chk("hs_no_overrun",          int'(overrun),    0);
      chk("hs_valid",               int'(pcm_valid),  1);

      // Reset pulsed mid-comb, then a full warm-up.
      pcm_ready = 1'b0;
      do_reset();
      pat = 4'b1111;
      repeat (390) step();
      chk("rc_overrun_before", int'(overrun), 1);
      repeat (450 - 390) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rc_valid_cleared",   int'(pcm_valid), 0);
      chk("rc_overrun_cleared", int'(overrun),   0);
      chk("rc_data_cleared",    pcm_s(),         0);
      cyc   = 0;
      nsamp = 0;
      first = -1;
      for (int c = 0; c < 400 && first < 0; c++) begin
         step();
         if (pcm_valid) first = cyc;
      end
      chk("rc_first_after_reset", first,   326);
      chk("rc_data_after_reset",  pcm_s(), 32767);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pdm_cic_decimator.md
PDM_CIC_DECIMATOR -- requirements
Module: pdm_cic_decimator

Interface
REQ-001 Parameter DEC_R, default 64: decimation ratio; power of two, 8..256.
REQ-002 Parameter OUT_W, default 16: signed PCM output width.
REQ-003 addr_clk  input  1  PDM bit clock (2 MHz); all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high; clock addr_clk.
REQ-005 pdm_in  input  1  PDM bit from the upstream PDM source/microphone; sampled when pdm_en=1.
REQ-006 pdm_en  input  1  qualifies pdm_in; cycles with pdm_en=0 leave all integrators and the frame counter unchanged.
REQ-007 pcm_data  output  OUT_W  signed decimated sample; stable while pcm_valid=1.
REQ-008 pcm_valid  output  1  sample available; held until accepted.
REQ-009 pcm_ready  input  1  consumer accepts when pcm_valid and pcm_ready are both 1 on a clock edge.
REQ-010 overrun  output  1  sticky; set when a sample is dropped.

Function
REQ-011 pdm_in SHALL map to +1 (1) or -1 (0) and feed a 4th-order CIC: 4 cascaded integrators at input rate, 4 combs (differential delay 1) at output rate.
REQ-012 Internal width SHALL be ACC_W = 1 + 4*log2(DEC_R) (25 for DEC_R=64), two's-complement, wrapping modulo 2^ACC_W with no saturation inside integrators or combs.
REQ-013 The frame counter SHALL count enabled samples 0..DEC_R-1 and wrap; the enabled cycle with count=DEC_R-1 is the frame boundary, at which the integrator-4 result is captured.
REQ-014 Combs SHALL be evaluated serially with one shared subtractor, FSM IDLE -> COMB (stage 0..3, one per cycle) -> EMIT -> IDLE.
REQ-015 IDLE leaves on a frame boundary only; COMB advances unconditionally; EMIT lasts one cycle.
REQ-016 Latency: frame boundary on cycle k SHALL give pcm_valid=1 at cycle k+6 (capture k+1, combs k+2..k+5, output register k+6).
REQ-017 Output scaling: comb result arithmetic-shifted right by 4*log2(DEC_R)-(OUT_W-1), then saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-018 The first 4 frames after reset SHALL be computed but not emitted (comb delay-line warm-up); the first pcm_valid follows frame 5.
REQ-019 If EMIT occurs while pcm_valid=1 and pcm_ready=0, pcm_data SHALL be overwritten with the new sample, pcm_valid SHALL stay 1, and overrun SHALL set.
REQ-020 If EMIT coincides with a handshake on the old sample, the new sample SHALL load, pcm_valid SHALL stay 1, and overrun SHALL not set.
REQ-021 A handshake with no EMIT in the same cycle SHALL clear pcm_valid on the next edge.
REQ-022 The frame counter and integrators SHALL keep running in every FSM state; DEC_R>=8 guarantees the FSM returns to IDLE before the next boundary.

Reset
REQ-023 Reset SHALL clear integrators, comb delays, frame counter, warm-up counter, pcm_data=0, pcm_valid=0, overrun=0, and FSM=IDLE.
REQ-024 Reset asserted mid-frame or mid-COMB SHALL abort the frame; the next output follows a full new warm-up.

Structure
REQ-025 Package pdm_pkg SHALL hold CIC_ORDER=4, the FSM state typedef, and the ACC_W/shift derivation functions.
REQ-026 Integrator stage SHALL be sub-module cic_integrator (enable, wrap-add), instantiated 4x; combs stay in the top level.

Verification (DEC_R=64, OUT_W=16)
REQ-027 pdm_in constant 1, pcm_ready=1 -> first pcm_valid after frame 5, pcm_data=32767 (2^24>>9 saturated), one valid per 64 enabled cycles.
REQ-028 pdm_in constant 0 -> pcm_data=-32768; alternating 1010... -> pcm_data=0; pattern 1110 repeating -> pcm_data=16384.
REQ-029 pdm_en toggling every other cycle with constant 1 -> output period 128 cycles, values identical to REQ-027.
REQ-030 pcm_ready=0 across 2 EMITs -> overrun=1, pcm_data = latest sample, pcm_valid held; ready pulse -> pcm_valid=0 next cycle, overrun stays 1.
REQ-031 EMIT and handshake in the same cycle -> pcm_valid stays 1, new data loaded, overrun=0.
REQ-032 Reset pulsed during COMB -> pcm_valid=0, overrun=0 next cycle; next pcm_valid exactly 5 frames + 6 cycles after reset release.
